keeper_control: RTL
===================

// Module: keeper_control
// PURPOSE
//  Goalkeeper-side round controller for MULTI mode; counterpart of the shooter controller on the remote board.
//  Tracks the local mouse to position the keeper, exports keeper_pos for UART transmission to the shooter.
//  Waits for the remote shot (coordinates over UART), judges goal/save and returns the verdict.
//  Draws the keeper overlay into the VGA stream (1-cycle pipeline). In SOLO the block is transparent and inert.
// PARAMETERS
//  SCREEN_W    1024      horizontal pixels; keeper_pos clamp reference
//  GK_WIDTH    200       keeper rectangle width
//  GK_HEIGHT   300       keeper rectangle height
//  GK_POS_Y    250       keeper rectangle top edge
//  GOAL_X_MIN  212       goal mouth left edge (inclusive)
//  GOAL_X_MAX  812       goal mouth right edge (inclusive)
//  GOAL_Y_MIN  170       goal mouth top edge (inclusive)
//  GOAL_Y_MAX  600       goal mouth bottom edge (inclusive)
//  HOLD_CYCLES 13003902  verdict display time in clk cycles
// PORTS
//  clk            in   1    system clock (single clock domain)
//  rst            in   1    synchronous, active-high reset
//  game_state     in   g_state  top FSM state; block runs only while KEEPER
//  game_mode      in   g_mode   SOLO / MULTI
//  xpos           in   12   mouse x, drives keeper position
//  enemy_shot     in   1    1-cycle pulse: remote shooter has shot (UART opcode decoded)
//  enemy_shot_x   in   12   remote shot x, valid with enemy_shot
//  enemy_shot_y   in   12   remote shot y, valid with enemy_shot
//  keeper_pos     out  10   keeper left edge, sent to shooter
//  round_done     out  1    1-cycle pulse: verdict valid (UART sends it to shooter as enemy_input)
//  is_scored      out  1    verdict: 1 goal, 0 save; held from round_done until TERMINATE
//  end_gk         out  1    1-cycle pulse: keeper round finished, top FSM advances
//  in             vga_if.in   upstream VGA stream
//  out            vga_if.out  downstream VGA stream, 1 cycle later
// BEHAVIOUR
//  Reset: all outputs 0, out.* 0, state IDLE, counter 0, latched shot 0, keeper_pos 0.
//  VGA: timing signals delayed 1 cycle; rgb registered; overlay on in.hcount/in.vcount in
//   [keeper_pos, keeper_pos+GK_WIDTH] x [GK_POS_Y, GK_POS_Y+GK_HEIGHT], inclusive.
//  SOLO: state forced IDLE, rgb passthrough, round_done/is_scored/end_gk 0.
//  Keeper position (DEFEND only, registered): target = xpos - GK_WIDTH/2 in signed 13-bit;
//   <0 -> 0; > SCREEN_W-GK_WIDTH (824) -> 824. Frozen in all other states; IDLE resets it to 0.
//  FSM (MULTI):
//   IDLE      -> ENGAGE when game_state==KEEPER; rgb passthrough.
//   ENGAGE    -> DEFEND if still KEEPER, else IDLE (absorbs top-FSM latency).
//   DEFEND    overlay blue 12'h00F; on enemy_shot latch x/y -> JUDGE. Exit to IDLE if game_state!=KEEPER.
//   JUDGE     1 cycle; scored = shot in goal rect AND NOT in keeper rect (frozen keeper_pos, inclusive).
//             -> GOAL or SAVE; round_done=1 and is_scored=scored on the entry cycle.
//   GOAL      overlay red 12'hF00, is_scored=1; counter++; at HOLD_CYCLES-1 -> TERMINATE.
//   SAVE      overlay green 12'h0F0, is_scored=0; same counting as GOAL.
//   TERMINATE 1 cycle: end_gk=1, is_scored cleared, counter 0 -> IDLE.
//  enemy_shot outside DEFEND is ignored; enemy_shot during ENGAGE is dropped.
//  Counter 24-bit, cleared on every state entry; no wrap possible below HOLD_CYCLES.
//  game_mode change mid-round: next cycle behaves as SOLO (state IDLE, outputs 0).
//  rst mid-round: all state and outputs to reset values on the next edge.
// TESTING (bench uses HOLD_CYCLES=16)
//  1 MULTI, KEEPER, xpos=500 -> keeper_pos=400 two cycles after DEFEND entry; xpos=50 -> 0; xpos=1000 -> 824.
//  2 keeper_pos=400, shot (300,400) -> round_done 1 cycle, is_scored=1, 16 cycles GOAL, end_gk pulse, IDLE.
//  3 keeper_pos=400, shot (500,400) -> is_scored=0, SAVE overlay 12'h0F0 at hcount 500/vcount 400.
//  4 shot (900,400) outside goal -> is_scored=0; edge shot (212,170) with keeper at 400 -> is_scored=1.
//  5 enemy_shot in IDLE or during GOAL -> no round_done; SOLO mode -> out.rgb==in.rgb delayed 1 cycle.
//  6 rst asserted during GOAL -> next cycle all outputs 0, state IDLE; rerun scenario 2 passes.

Source files
------------

// File: rtl/keeper_control.sv
// rtl/keeper_control.sv - goalkeeper-side MULTI round controller with keeper overlay on the VGA stream
module keeper_control #(
    parameter int         SCREEN_W     = 1024,
    parameter int         GK_WIDTH     = 200,
    parameter int         GK_HEIGHT    = 300,
    parameter int         GK_POS_Y     = 250,
    parameter int         GOAL_X_MIN   = 212,
    parameter int         GOAL_X_MAX   = 812,
    parameter int         GOAL_Y_MIN   = 170,
    parameter int         GOAL_Y_MAX   = 600,
    parameter int         HOLD_CYCLES  = 13003902,
    parameter logic [2:0] KEEPER_STATE = 3'd2,
    parameter logic       MODE_MULTI   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  game_state,
    input  logic        game_mode,
    input  logic [11:0] xpos,
    input  logic        enemy_shot,
    input  logic [11:0] enemy_shot_x,
    input  logic [11:0] enemy_shot_y,
    output logic [9:0]  keeper_pos,
    output logic        round_done,
    output logic        is_scored,
    output logic        end_gk,
    input  logic [10:0] in_hcount,
    input  logic [10:0] in_vcount,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblnk,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,
    output logic [10:0] out_hcount,
    output logic [10:0] out_vcount,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_hblnk,
    output logic        out_vblnk,
    output logic [11:0] out_rgb
);

    typedef enum logic [2:0] {
        IDLE, ENGAGE, DEFEND, JUDGE, GOAL, SAVE, TERMINATE
    } state_t;

    localparam logic signed [12:0] POS_MAX   = 13'(SCREEN_W - GK_WIDTH);
    localparam logic signed [12:0] HALF_W    = 13'(GK_WIDTH / 2);
    localparam logic [23:0]        HOLD_LAST = 24'(HOLD_CYCLES - 1);

    state_t             state, state_next;
    logic [23:0]        counter;
    logic [11:0]        shot_x, shot_y;
    logic [11:0]        kp_left, kp_right;
    logic signed [12:0] target;
    logic [9:0]         pos_next;
    logic               multi, keeper_active, scored, shot_in_goal, shot_on_keeper;
    logic               pixel_on_keeper, overlay;
    logic [11:0]        overlay_rgb;

    assign multi         = (game_mode == MODE_MULTI);
    assign keeper_active = (game_state == KEEPER_STATE);
    assign kp_left       = {2'b00, keeper_pos};
    assign kp_right      = kp_left + 12'(GK_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (keeper_active) state_next = ENGAGE;
            ENGAGE:    state_next = keeper_active ? DEFEND : IDLE;
            DEFEND: begin
                if (!keeper_active)  state_next = IDLE;
                else if (enemy_shot) state_next = JUDGE;
            end
            JUDGE:     state_next = scored ? GOAL : SAVE;
            GOAL,
            SAVE:      if (counter == HOLD_LAST) state_next = TERMINATE;
            TERMINATE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (!multi) state_next = IDLE;
    end

    // Counter restarts on every state change, so GOAL/SAVE last exactly HOLD_CYCLES
    always_ff @(posedge clk) begin
        if (rst || state_next != state) begin
            counter <= '0;
        end else if (state == GOAL || state == SAVE) begin
            counter <= counter + 24'd1;
        end
    end

    always_comb begin
        target = $signed({1'b0, xpos}) - HALF_W;
        if (target < 0) begin
            pos_next = '0;
        end else if (target > POS_MAX) begin
            pos_next = POS_MAX[9:0];
        end else begin
            pos_next = target[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            keeper_pos <= '0;
        end else if (state == DEFEND) begin
            keeper_pos <= pos_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shot_x <= '0;
            shot_y <= '0;
        end else if (state == DEFEND && state_next == JUDGE) begin
            shot_x <= enemy_shot_x;
            shot_y <= enemy_shot_y;
        end
    end

    // Judged against the keeper position frozen at the moment of the shot
    always_comb begin
        shot_in_goal   = shot_x >= 12'(GOAL_X_MIN) && shot_x <= 12'(GOAL_X_MAX) &&
                         shot_y >= 12'(GOAL_Y_MIN) && shot_y <= 12'(GOAL_Y_MAX);
        shot_on_keeper = shot_x >= kp_left && shot_x <= kp_right &&
                         shot_y >= 12'(GK_POS_Y) && shot_y <= 12'(GK_POS_Y + GK_HEIGHT);
        scored         = shot_in_goal && !shot_on_keeper;
    end

    assign round_done = multi && (state == GOAL || state == SAVE) && counter == '0;
    assign is_scored  = multi && state == GOAL;
    assign end_gk     = multi && state == TERMINATE;

    always_comb begin
        pixel_on_keeper = {1'b0, in_hcount} >= kp_left && {1'b0, in_hcount} <= kp_right &&
                          {1'b0, in_vcount} >= 12'(GK_POS_Y) &&
                          {1'b0, in_vcount} <= 12'(GK_POS_Y + GK_HEIGHT);
        overlay_rgb = 12'h00F;
        overlay     = 1'b0;
        case (state)
            DEFEND: begin overlay_rgb = 12'h00F; overlay = 1'b1; end
            GOAL:   begin overlay_rgb = 12'hF00; overlay = 1'b1; end
            SAVE:   begin overlay_rgb = 12'h0F0; overlay = 1'b1; end
            default: overlay = 1'b0;
        endcase
        overlay = overlay && multi && pixel_on_keeper;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_hcount <= '0;
            out_vcount <= '0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            out_hcount <= in_hcount;
            out_vcount <= in_vcount;
            out_hsync  <= in_hsync;
            out_vsync  <= in_vsync;
            out_hblnk  <= in_hblnk;
            out_vblnk  <= in_vblnk;
            out_rgb    <= overlay ? overlay_rgb : in_rgb;
        end
    end

endmodule
